// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer.
// The SER_PARITY state exists only when BIT_SERIALIZER_PARITY_EN is defined.
package bit_serializer_pkg;

    localparam int unsigned SER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SHIFT
`ifdef BIT_SERIALIZER_PARITY_EN
        ,
        SER_PARITY
`endif
    } ser_state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake plus serial stream bundle between a word producer and the serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = bit_serializer_pkg::SER_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_start;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, word_start, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, word_start, busy
    );
endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer that lets the next word wait while the shifter is busy.
// Owns in_ready: ready whenever the slot is empty and reset is released.
module ser_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             in_ready_o
);
    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_i) begin
                data_q <= wdata_i;
                full_q <= 1'b1;
            end else if (rd_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign rdata_o    = data_q;
    assign full_o     = full_q;
    assign in_ready_o = !reset && !full_q;
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words out MSB-first on a registered line.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             reset,
    bit_serializer_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_start_q, word_start_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             hold_full, hold_wr, hold_rd;
    logic [WIDTH-1:0] hold_data, load_word;
    logic             accept, last_bit, eow, load;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_bit = (state_q == SER_SHIFT) && (cnt_q == '0);
`ifdef BIT_SERIALIZER_PARITY_EN
    assign eow      = (state_q == SER_PARITY);
`else
    assign eow      = last_bit;
`endif
    // A held word always wins at end-of-word; in_ready is low then, so no accept can collide.
    assign load      = ((state_q == SER_IDLE) && accept) || (eow && (hold_full || accept));
    assign load_word = (eow && hold_full) ? hold_data : bus.in_data;
    assign hold_rd   = eow && hold_full;
    assign hold_wr   = accept && (state_q != SER_IDLE) && !eow;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (hold_wr),
        .rd_i      (hold_rd),
        .wdata_i   (bus.in_data),
        .rdata_o   (hold_data),
        .full_o    (hold_full),
        .in_ready_o(bus.in_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SER_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            word_start_q <= word_start_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE: if (accept) state_d = SER_SHIFT;
            SER_SHIFT: begin
                if (last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = SER_PARITY;
`else
                    state_d = load ? SER_SHIFT : SER_IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            SER_PARITY: state_d = load ? SER_SHIFT : SER_IDLE;
`endif
            default: state_d = SER_IDLE;
        endcase
    end

    // shift_q holds the bits still to come, left-aligned; ser_out_q is the bit on the wire.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        word_start_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d     = parity_q;
`endif
        if (load) begin
            shift_d      = load_word << 1;
            cnt_d        = CntW'(WIDTH - 1);
            ser_out_d    = load_word[WIDTH-1];
            ser_valid_d  = 1'b1;
            word_start_d = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_d     = ^load_word;
`endif
        end else if ((state_q == SER_SHIFT) && !last_bit) begin
            shift_d   = shift_q << 1;
            cnt_d     = cnt_q - CntW'(1);
            ser_out_d = shift_q[WIDTH-1];
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        else if (last_bit) begin
            ser_out_d = parity_q;
        end
`endif
        else begin
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
        end
    end

    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.word_start = word_start_q;
    assign bus.busy       = (state_q != SER_IDLE) || hold_full;
endmodule
